// File: rtl/axist_rr_arb.sv
// Round-robin arbiter: NUM_SRC valid/ready/last stream sources share one sink.
// A granted source owns the sink until its last beat is accepted.
module axist_rr_arb #(
  parameter int NUM_SRC = 4,
  parameter int DW      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         s_valid,
  input  logic [NUM_SRC*DW-1:0]      s_data,
  input  logic [NUM_SRC-1:0]         s_last,
  output logic [NUM_SRC-1:0]         s_ready,
  output logic                       m_valid,
  output logic [DW-1:0]              m_data,
  output logic                       m_last,
  input  logic                       m_ready,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic                       busy
);

  localparam int GW = $clog2(NUM_SRC);

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] pick, idx;
  logic          found;
  logic [DW-1:0] src_data [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_data[i] = s_data[i*DW +: DW];
  end

  // First requester strictly after rr_ptr, so the last owner ranks lowest.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = GW'((int'(rr_ptr_q) + k) % NUM_SRC);
      if (!found && s_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign busy     = (state_q == ST_BUSY);
  assign grant_id = grant_q;
  assign m_valid  = busy & s_valid[grant_q];
  assign m_data   = src_data[grant_q];
  assign m_last   = s_last[grant_q];

  always_comb begin
    s_ready = '0;
    if (busy) s_ready[grant_q] = m_ready;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_BUSY;
          grant_d = pick;
        end
      end
      ST_BUSY: begin
        if (m_valid && m_ready && m_last) begin
          state_d  = ST_IDLE;
          rr_ptr_d = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= GW'(NUM_SRC - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_axist_rr_arb.sv
// Bench for axist_rr_arb: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a packet-level ownership model.
module tb_axist_rr_arb;
  localparam int NS = 4;
  localparam int DW = 8;
  localparam int GW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NS-1:0]     s_valid = '0, s_last = '0, s_ready;
  logic [NS*DW-1:0]  s_data = '0;
  logic              m_valid, m_last, busy;
  logic              m_ready = 1'b1;
  logic [DW-1:0]     m_data;
  logic [GW-1:0]     grant_id;

  axist_rr_arb #(.NUM_SRC(NS), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int owner, ptr;                 // model: owning source (-1 = none), last owner
  int pkts[NS], plen[NS], beat[NS];
  logic [DW-1:0] dbase[NS];
  logic bub[NS];
  logic busy_prev;
  int gq[$];                      // observed grant sequence
  int rx[$];                      // observed sink beats

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic chk_list(string tag, int got[$], int exp[$]);
    chk({tag, "_len"}, got.size(), exp.size());
    foreach (exp[i]) if (i < got.size()) chk(tag, got[i], exp[i]);
  endtask

  function automatic logic pending();
    logic p = 1'b0;
    for (int i = 0; i < NS; i++) if (pkts[i] > 0) p = 1'b1;
    return p;
  endfunction

  task automatic clear_srcs();
    for (int i = 0; i < NS; i++) begin
      pkts[i] = 0; plen[i] = 1; beat[i] = 0; dbase[i] = '0; bub[i] = 1'b0;
    end
    s_valid = '0;
    s_last  = '0;
    m_ready = 1'b1;
  endtask

  task automatic load(int i, int n, int len, logic [DW-1:0] base);
    pkts[i] = n; plen[i] = len; beat[i] = 0; dbase[i] = base;
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < NS; i++) begin
      s_valid[i] = (pkts[i] > 0) && !bub[i];
      if (pkts[i] > 0) begin
        s_data[i*DW +: DW] = dbase[i] + DW'(beat[i]);
        s_last[i] = (beat[i] == plen[i] - 1);
      end else begin
        s_data[i*DW +: DW] = DW'($urandom);
        s_last[i] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic advance(int i);
    beat[i]++;
    if (beat[i] == plen[i]) begin
      beat[i] = 0;
      dbase[i] = dbase[i] + DW'(plen[i]);
      pkts[i]--;
    end
  endtask

  // One clock: drive, compare against the model, update model, wait a cycle.
  task automatic step();
    logic [NS-1:0] e_rdy;
    logic e_mv, e_ml;
    logic [DW-1:0] e_md;
    drive_srcs();
    #1;
    e_rdy = '0; e_mv = 1'b0; e_ml = 1'b0; e_md = '0;
    if (owner >= 0) begin
      e_mv = s_valid[owner];
      e_md = s_data[owner*DW +: DW];
      e_ml = s_last[owner];
      e_rdy[owner] = m_ready;
    end
    chk("busy", busy, owner >= 0);
    if (owner >= 0) chk("grant_id", grant_id, owner);
    chk("m_valid", m_valid, e_mv);
    chk("s_ready", s_ready, e_rdy);
    if (e_mv) begin
      chk("m_data", m_data, e_md);
      chk("m_last", m_last, e_ml);
    end
    if (busy && !busy_prev) gq.push_back(int'(grant_id));
    busy_prev = busy;
    if (m_valid && m_ready) rx.push_back(int'(m_data));
    for (int i = 0; i < NS; i++) if (s_valid[i] && e_rdy[i]) advance(i);
    if (owner < 0) begin
      for (int k = 1; k <= NS; k++) begin
        if (owner < 0 && s_valid[(ptr + k) % NS]) owner = (ptr + k) % NS;
      end
    end else if (e_mv && m_ready && e_ml) begin
      ptr = owner;
      owner = -1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant_id, 0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_s_ready", s_ready, '0);
    clear_srcs();
    owner = -1; ptr = NS - 1; busy_prev = 1'b0; cyc = 0;
    gq.delete(); rx.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_done(int maxc);
    int n = 0;
    while ((owner >= 0 || pending()) && n < maxc) begin
      step();
      n++;
    end
    chk("timeout", (owner >= 0 || pending()), 1'b0);
  endtask

  initial begin
    clear_srcs();
    @(negedge clk);

    // 1: single 4-beat packet from src0
    do_reset();
    load(0, 1, 4, 8'd1);
    run_done(50);
    chk("t1_cycles", cyc, 5);
    chk_list("t1_grants", gq, '{0});
    chk_list("t1_data", rx, '{1, 2, 3, 4});

    // 2: all sources request 2-beat packets, src0 has two
    do_reset();
    load(0, 2, 2, 8'h00); load(1, 1, 2, 8'h10);
    load(2, 1, 2, 8'h20); load(3, 1, 2, 8'h30);
    run_done(100);
    chk("t2_cycles", cyc, 15);
    chk_list("t2_grants", gq, '{0, 1, 2, 3, 0});

    // 3: stall while src2 owns, src0 waiting
    do_reset();
    load(2, 1, 4, 8'h20);
    step(); step();
    load(0, 1, 1, 8'h05);
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t3_hold_grant", grant_id, 2);
      chk("t3_hold_rdy", s_ready, '0);
    end
    chk("t3_beats_in_stall", rx.size(), 1);
    m_ready = 1'b1;
    run_done(50);
    chk_list("t3_data", rx, '{8'h20, 8'h21, 8'h22, 8'h23, 8'h05});
    chk_list("t3_grants", gq, '{2, 0});

    // 4: src1 finishes while src0 and src3 request
    do_reset();
    load(1, 1, 2, 8'h10);
    step(); step();
    load(0, 1, 1, 8'h00); load(3, 1, 1, 8'h30);
    run_done(50);
    chk_list("t4_grants", gq, '{1, 3, 0});

    // 5: src0 bubble mid-packet, src1 waiting
    do_reset();
    load(0, 1, 4, 8'h50); load(1, 1, 2, 8'h60);
    step(); step(); step();
    bub[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_bubble_mv", m_valid, 1'b0);
      chk("t5_bubble_grant", grant_id, 0);
    end
    bub[0] = 1'b0;
    run_done(50);
    chk_list("t5_grants", gq, '{0, 1});
    chk_list("t5_data", rx, '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60, 8'h61});

    // 6: reset during beat 2 of an 8-beat packet
    do_reset();
    load(0, 1, 8, 8'h70); load(1, 1, 2, 8'h80);
    step(); step();
    chk("t6_pre_busy", busy, 1'b1);
    do_reset();
    load(0, 1, 8, 8'h70); load(1, 1, 2, 8'h80);
    run_done(50);
    chk_list("t6_grants", gq, '{0, 1});

    // Randomized traffic with one reset in the middle
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      m_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NS; i++) begin
        bub[i] = ($urandom_range(0, 4) == 0);
        if (pkts[i] == 0 && $urandom_range(0, 3) == 0)
          load(i, 1, int'($urandom_range(1, 5)), DW'($urandom));
      end
      step();
    end
    for (int i = 0; i < NS; i++) bub[i] = 1'b0;
    m_ready = 1'b1;
    run_done(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
